// File: rtl/ether_tx_framer.sv
// RMII transmit framer: wraps an upstream dibit stream with preamble/SFD and a
// trailing CRC-32 FCS, then holds the line idle for the inter-frame gap.
module ether_tx_framer #(
    parameter int IFG_DIBITS = 48
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       axiiv,
    input  logic [1:0] axiid,
    input  logic       axiil,
    output logic       axiir,
    output logic       axiov,
    output logic [1:0] axiod,
    output logic       err
);

    localparam int              IFG_W    = $clog2(IFG_DIBITS + 1);
    localparam logic [IFG_W-1:0] IFG_LAST = IFG_W'(IFG_DIBITS - 1);
    localparam logic [31:0]     CRC_POLY = 32'h04C1_1DB7;

    typedef enum logic [2:0] {IDLE, PRE, PAY, FCS, IFG} state_t;

    state_t             state_reg;
    logic [4:0]         pre_cnt_reg;
    logic [3:0]         fcs_cnt_reg;
    logic [IFG_W-1:0]   ifg_cnt_reg;
    logic [31:0]        crc_reg;
    logic               axiov_reg;
    logic [1:0]         axiod_reg;
    logic               err_reg;

    // axiid[0] is shifted in first; register is kept non-reflected.
    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [1:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 2; i++) begin
            r = {r[30:0], 1'b0} ^ ((r[31] ^ d[i]) ? CRC_POLY : 32'h0);
        end
        return r;
    endfunction

    // The SFD cycle accepts the first payload dibit so it lands right behind the SFD.
    assign axiir = (state_reg == PAY) || ((state_reg == PRE) && (pre_cnt_reg == 5'd31));
    assign axiov = axiov_reg;
    assign axiod = axiod_reg;
    assign err   = err_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            pre_cnt_reg <= '0;
            fcs_cnt_reg <= '0;
            ifg_cnt_reg <= '0;
            crc_reg     <= 32'hFFFF_FFFF;
            axiov_reg   <= 1'b0;
            axiod_reg   <= 2'b00;
            err_reg     <= 1'b0;
        end else begin
            err_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    axiov_reg <= 1'b0;
                    axiod_reg <= 2'b00;
                    if (axiiv) begin
                        state_reg   <= PRE;
                        pre_cnt_reg <= '0;
                        crc_reg     <= 32'hFFFF_FFFF;
                        axiov_reg   <= 1'b1;
                        axiod_reg   <= 2'b01;
                    end
                end
                PRE, PAY: begin
                    if (!axiir) begin
                        pre_cnt_reg <= pre_cnt_reg + 5'd1;
                        axiod_reg   <= (pre_cnt_reg == 5'd30) ? 2'b11 : 2'b01;
                    end else if (axiiv) begin
                        axiov_reg <= 1'b1;
                        axiod_reg <= axiid;
                        crc_reg   <= crc_step(crc_reg, axiid);
                        if (axiil) begin
                            state_reg   <= FCS;
                            fcs_cnt_reg <= '0;
                        end else begin
                            state_reg <= PAY;
                        end
                    end else begin
                        // Source starved while we owed it a dibit: abort without FCS.
                        axiov_reg   <= 1'b0;
                        axiod_reg   <= 2'b00;
                        err_reg     <= 1'b1;
                        state_reg   <= IFG;
                        ifg_cnt_reg <= '0;
                    end
                end
                FCS: begin
                    // Complemented register goes out MSB first; shift rather than index.
                    axiod_reg <= {~crc_reg[30], ~crc_reg[31]};
                    crc_reg   <= {crc_reg[29:0], 2'b11};
                    if (fcs_cnt_reg == 4'd15) begin
                        state_reg   <= IFG;
                        ifg_cnt_reg <= '0;
                    end else begin
                        fcs_cnt_reg <= fcs_cnt_reg + 4'd1;
                    end
                end
                IFG: begin
                    axiov_reg <= 1'b0;
                    axiod_reg <= 2'b00;
                    if (ifg_cnt_reg == IFG_LAST) begin
                        state_reg <= IDLE;
                    end else begin
                        ifg_cnt_reg <= ifg_cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ether_tx_framer.sv
// Directed bench for ether_tx_framer: records a per-cycle trace of the wire and
// compares framing, handshake timing and FCS against hand values and a CRC model.
module tb_ether_tx_framer;

    localparam int IFG = 48;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       axiiv = 1'b0;
    logic [1:0] axiid = 2'b00;
    logic       axiil = 1'b0;
    logic       axiir;
    logic       axiov;
    logic [1:0] axiod;
    logic       err;

    ether_tx_framer #(.IFG_DIBITS(IFG)) dut (
        .clk   (clk),
        .rst   (rst),
        .axiiv (axiiv),
        .axiid (axiid),
        .axiil (axiil),
        .axiir (axiir),
        .axiov (axiov),
        .axiod (axiod),
        .err   (err)
    );

    always #10 clk = ~clk;

    typedef struct packed {
        logic       ov;
        logic [1:0] od;
        logic       er;
        logic       ir;
        logic       xfer;
        logic [1:0] xd;
    } cyc_t;

    typedef struct packed {
        logic [1:0] d;
        logic       l;
    } src_t;

    typedef logic [7:0] bq_t[$];
    typedef logic [1:0] dq_t[$];

    cyc_t trace[$];
    src_t src_q[$];
    int   sent;
    int   drop_at = -1;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reflected (LSB-first) CRC-32 reference; wire bit i of the FCS is bit i of the result.
    function automatic logic [31:0] fcs_model(input dq_t p);
        logic [31:0] r;
        r = 32'hFFFF_FFFF;
        foreach (p[j]) begin
            for (int k = 0; k < 2; k++) begin
                if (r[0] ^ p[j][k]) r = (r >> 1) ^ 32'hEDB8_8320;
                else                r = r >> 1;
            end
        end
        return ~r;
    endfunction

    function automatic dq_t to_dibits(input bq_t b);
        dq_t p;
        foreach (b[j]) begin
            p.push_back(b[j][1:0]);
            p.push_back(b[j][3:2]);
            p.push_back(b[j][5:4]);
            p.push_back(b[j][7:6]);
        end
        return p;
    endfunction

    function automatic logic [127:0] pack(input dq_t p);
        logic [127:0] v;
        v = '0;
        foreach (p[j]) v[2*j +: 2] = p[j];
        return v;
    endfunction

    task automatic queue_frame(input dq_t p);
        src_t s;
        foreach (p[j]) begin
            s.d = p[j];
            s.l = (j == p.size() - 1);
            src_q.push_back(s);
        end
    endtask

    // One cycle: drive the source at the falling edge and log what the wire shows.
    task automatic step();
        cyc_t e;
        logic lst;
        @(negedge clk);
        if (drop_at >= 0 && sent == drop_at && axiir) begin
            axiiv = 1'b0;
            axiid = 2'b00;
            axiil = 1'b0;
            drop_at = -1;
            lst = 1'b0;
            while (!lst && src_q.size() > 0) begin
                lst = src_q[0].l;
                void'(src_q.pop_front());
            end
        end else if (src_q.size() > 0) begin
            axiiv = 1'b1;
            axiid = src_q[0].d;
            axiil = src_q[0].l;
        end else begin
            axiiv = 1'b0;
            axiid = 2'b00;
            axiil = 1'b0;
        end
        e.ov = axiov;
        e.od = axiod;
        e.er = err;
        e.ir = axiir;
        e.xfer = axiiv & axiir;
        e.xd = axiid;
        trace.push_back(e);
        if (e.xfer) begin
            void'(src_q.pop_front());
            sent++;
        end
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic new_test();
        trace.delete();
        sent = 0;
    endtask

    function automatic int count_ov(input int from, input int to);
        int c;
        c = 0;
        for (int i = from; i < to && i < trace.size(); i++) if (trace[i].ov) c++;
        return c;
    endfunction

    function automatic int count_ir(input int from, input int to);
        int c;
        c = 0;
        for (int i = from; i < to && i < trace.size(); i++) if (trace[i].ir) c++;
        return c;
    endfunction

    task automatic check_frame(input string nm, input int from, input dq_t p,
                               input logic [31:0] exp_fcs, output int s, output int e);
        int n, len, fi, nx, lat_bad;
        logic [127:0] pre_v, pay_v, fcs_v;
        n = p.size();
        s = -1;
        for (int i = from; i < trace.size(); i++) begin
            if (trace[i].ov) begin
                s = i;
                break;
            end
        end
        if (s < 0) begin
            check_eq({nm, "_found"}, 0, 1);
            e = from;
            return;
        end
        len = 0;
        while (s + len < trace.size() && trace[s + len].ov) len++;
        e = s + len;
        check_eq({nm, "_len"}, len, 48 + n);
        if (len < 48 + n) return;
        pre_v = '0;
        pay_v = '0;
        fcs_v = '0;
        for (int j = 0; j < 32; j++) pre_v[2*j +: 2] = trace[s + j].od;
        for (int j = 0; j < n; j++)  pay_v[2*j +: 2] = trace[s + 32 + j].od;
        for (int j = 0; j < 16; j++) fcs_v[2*j +: 2] = trace[s + 32 + n + j].od;
        check_eq({nm, "_preamble"}, pre_v, 64'hD555_5555_5555_5555);
        check_eq({nm, "_payload"}, pay_v, pack(p));
        check_eq({nm, "_fcs"}, fcs_v, exp_fcs);
        fi = -1;
        for (int i = from; i < e; i++) begin
            if (trace[i].ir) begin
                fi = i;
                break;
            end
        end
        check_eq({nm, "_ir_rise"}, fi - s, 31);
        nx = 0;
        lat_bad = 0;
        for (int i = from; i < e; i++) begin
            if (trace[i].xfer) begin
                nx++;
                if (!trace[i + 1].ov || trace[i + 1].od !== trace[i].xd) lat_bad++;
            end
        end
        check_eq({nm, "_xfers"}, nx, n);
        check_eq({nm, "_ir_cycles"}, count_ir(from, e), n);
        check_eq({nm, "_latency_bad"}, lat_bad, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t  b;
        dq_t  p1, p2, pu, p3, p0;
        int   s, e, s2, e2, ne, ei;

        // Reset values
        #2 rst = 1'b0;
        #3;
        check_eq("rst_axiov", axiov, 0);
        check_eq("rst_axiod", axiod, 0);
        check_eq("rst_axiir", axiir, 0);
        check_eq("rst_err", err, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        new_test();
        run(10);
        check_eq("idle_ov", count_ov(0, trace.size()), 0);
        check_eq("idle_ir", count_ir(0, trace.size()), 0);

        // "123456789": FCS on the wire is 26 39 F4 CB
        b = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        p1 = to_dibits(b);
        check_eq("std_payload_const", pack(p1), 72'h39_3837_3635_3433_3231);
        new_test();
        queue_frame(p1);
        run(200);
        check_frame("std", 0, p1, 32'hCBF4_3926, s, e);
        check_eq("std_fcs_first4", {trace[e-16].od, trace[e-15].od, trace[e-14].od, trace[e-13].od},
                 8'b10_01_10_00);
        check_eq("std_idle_after", count_ov(e, e + IFG), 0);

        // Back-to-back, valid held through the gap
        b = '{8'hA5, 8'h3C, 8'h00, 8'hFF};
        p2 = to_dibits(b);
        new_test();
        queue_frame(p1);
        queue_frame(p2);
        run(300);
        check_frame("b2b1", 0, p1, 32'hCBF4_3926, s, e);
        check_frame("b2b2", e, p2, fcs_model(p2), s2, e2);
        check_eq("b2b_gap", s2 - e, IFG);
        check_eq("b2b_total_xfers", sent, 52);

        // Underrun after 10 payload dibits, then a clean frame
        b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        pu = to_dibits(b);
        b = '{8'hDE, 8'hAD};
        p3 = to_dibits(b);
        new_test();
        queue_frame(pu);
        queue_frame(p3);
        drop_at = 10;
        run(260);
        s = -1;
        for (int i = 0; i < trace.size(); i++) begin
            if (trace[i].ov) begin
                s = i;
                break;
            end
        end
        if (s < 0) begin
            check_eq("unr_found", 0, 1);
        end else begin
            e = s;
            while (e < trace.size() && trace[e].ov) e++;
            check_eq("unr_len", e - s, 42);
            ne = 0;
            ei = -1;
            for (int i = 0; i < trace.size(); i++) begin
                if (trace[i].er) begin
                    ne++;
                    if (ei < 0) ei = i;
                end
            end
            check_eq("unr_err_pulses", ne, 1);
            check_eq("unr_err_pos", ei - s, 42);
            check_frame("unr_next", e, p3, fcs_model(p3), s2, e2);
            check_eq("unr_gap_ok", (s2 - e) >= IFG, 1);
        end

        // Reset asserted in the middle of the payload
        new_test();
        queue_frame(p1);
        for (int i = 0; i < 100 && sent < 5; i++) step();
        check_eq("rstm_reached_pay", sent >= 5, 1);
        #2 rst = 1'b0;
        #1;
        check_eq("rstm_axiov", axiov, 0);
        check_eq("rstm_axiir", axiir, 0);
        check_eq("rstm_axiod", axiod, 0);
        src_q.delete();
        axiiv = 1'b0;
        axiid = 2'b00;
        axiil = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        new_test();
        run(10);
        check_eq("rstm_quiet_ov", count_ov(0, trace.size()), 0);
        check_eq("rstm_quiet_ir", count_ir(0, trace.size()), 0);

        // Single-dibit frame
        p0.push_back(2'b11);
        new_test();
        queue_frame(p0);
        run(80);
        check_frame("one", 0, p0, fcs_model(p0), s, e);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ether_tx_framer.md
Name: ether_tx_framer

Overview:
- RMII transmit framer. Sits between the packet source (byte-to-dibit serializer) and the RMII TX pins.
- Accepts a frame as a stream of dibits with valid/ready/last, starting at the destination MAC and already padded to minimum length.
- Prepends preamble and SFD, forwards the payload, then appends the Ethernet FCS, which it computes internally with a 2-bit-per-cycle CRC-32.
- Enforces the inter-frame gap before accepting the next frame.

Parameters:
- IFG_DIBITS, 48, idle output cycles after the last FCS dibit (96 bit times at 2 bits/cycle).

Ports:
- clk  input  1  RMII reference clock (50 MHz). One dibit per cycle.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- axiiv  input  1  upstream dibit valid.
- axiid  input  2  upstream dibit. axiid[0] is first on the wire.
- axiil  input  1  last dibit of frame. Meaningful only when axiiv=1.
- axiir  output  1  ready. A transfer occurs when axiiv & axiir.
- axiov  output  1  TX enable (TXEN).
- axiod  output  2  TX dibit (TXD). axiod[0] is the earlier bit.
- err  output  1  one-cycle pulse on underrun abort.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; axiov=0, axiod=2'b00, axiir=0, err=0; CRC register=32'hFFFF_FFFF; counters=0. Reset mid-frame truncates immediately; nothing further is emitted.
- All outputs are registered except axiir, which is decoded combinationally from state and counter.
- States: IDLE, PRE, PAY, FCS, IFG.
- IDLE:
  - axiir=0, axiov=0.
  - axiiv=1 at an edge → PRE, count=0. The frame's first dibit stays held upstream; it is not consumed.
- PRE:
  - 32 output cycles with axiov=1.
  - Output cycles 0..30: axiod=2'b01. Output cycle 31: axiod=2'b11 (0x55 x7, then 0xD5, LSB-first dibits).
  - axiir=1 during output cycle 31, so the first payload dibit appears on the next cycle. The CRC is initialised to FFFFFFFF on entry.
- PAY:
  - Each transfer loads axiod<=axiid and axiov<=1 at the same edge; latency is 1 cycle.
  - The CRC advances by that dibit at the same edge.
  - axiir stays 1 until the transfer with axiil=1. At that edge: state → FCS, count=0, axiir=0.
- Underrun: a cycle in PAY with axiir=1 and axiiv=0:
  - Next edge: axiov=0, err=1 for one cycle, state → IFG. No FCS is sent.
  - Upstream discards the rest of the frame.
- CRC update:
  - Polynomial 0x04C11DB7, non-reflected register c.
  - Bit b=axiid[0] first: c = {c[30:0],0} ^ (c[31]^b ? poly : 0). Then the same step with axiid[1].
  - Preamble and SFD are not included.
- FCS:
  - f = ~c after the last payload dibit.
  - 16 output cycles, k=0..15: axiod[0]=f[31-2k], axiod[1]=f[30-2k], axiov=1.
  - After k=15: state → IFG, count=0.
- IFG: axiov=0, axiod=2'b00, axiir=0 for IFG_DIBITS cycles, then IDLE.
- axiiv asserted during FCS/IFG is ignored. The frame waits upstream (axiir=0) and starts PRE on the first edge in IDLE.
- A single-dibit frame (axiil=1 on the first transfer) is legal: PRE → PAY (1 cycle) → FCS.
- Back-to-back frames: from the first PRE cycle of frame N, output cycles are 32 + payload_dibits + 16 + IFG_DIBITS; frame N+1's PRE starts at the earliest one cycle after IDLE is entered.
- Counters: 5-bit for PRE, 4-bit for FCS, clog2(IFG_DIBITS+1)-bit for IFG. No wrap is reachable.

Test Plan:
- Reset: rst=0 during PAY → same cycle axiov=0 and axiir=0. After release, IDLE with no output until axiiv.
- Frame of ASCII "123456789" (36 dibits, LSB-first per byte), continuous valid:
  - axiov high for 32+36+16=84 consecutive cycles, axiod matching preamble, SFD and payload.
  - FCS on wire is bytes 26 39 F4 CB; first four FCS dibits are 2'b10, 2'b01, 2'b10, 2'b00.
  - Then exactly 48 cycles of axiov=0.
- Latency/handshake: verify axiir first rises in the SFD output cycle. Each accepted dibit appears on axiod exactly 1 cycle later. No transfer occurs while in PRE cycles 0..30, FCS or IFG.
- Underrun: drop axiiv for one cycle mid-payload → next cycle axiov=0 and a single err pulse. No FCS. IFG_DIBITS idle cycles, then a new frame framed correctly.
- Back-to-back frames with axiiv held high through the gap: second preamble starts exactly 48 idle cycles after the first FCS ends. The second FCS is correct, proving the CRC is re-initialised.
- One-dibit frame axiid=2'b11, axiil=1: 32 preamble/SFD dibits, 1 payload dibit, 16 FCS dibits matching the reference-model CRC.
